// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/handshake/result bundle between the control unit and muldiv_unit.
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;
  modport master(output start, op, a, b, input busy, done, hi, lo, div_zero);
  modport slave(input start, op, a, b, output busy, done, hi, lo, div_zero);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: shared iterative signed/unsigned multiply and restoring divide engine.
// Define MULDIV_EARLY_OUT_EN to let multiplies finish once the remaining multiplier is zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mc;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mp;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH:0]     div_t;
  logic [WIDTH:0]     div_d;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg;
  logic               neg_rem;
  logic               a_neg;
  logic               b_neg;
  logic               mul_last;
  // Divide reuses the multiply registers: acc low half is the partial remainder,
  // mp shifts the dividend out and the quotient in, mc low half holds the divisor.
  always_comb begin
    a_neg = ~bus.op[1] & bus.a[WIDTH-1];
    b_neg = ~bus.op[1] & bus.b[WIDTH-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
    div_t = {acc[WIDTH-1:0], mp[WIDTH-1]};
    div_d = div_t - {1'b0, mc[WIDTH-1:0]};
    prod = neg ? -acc : acc;
    quo = neg ? -mp : mp;
    rem = neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
`ifdef MULDIV_EARLY_OUT_EN
    mul_last = mp[WIDTH-1:1] == '0;
`else
    mul_last = cnt == LAST;
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
      bus.hi       <= '0;
      bus.lo       <= '0;
      acc          <= '0;
      mc           <= '0;
      mp           <= '0;
      cnt          <= '0;
      is_div       <= 1'b0;
      neg          <= 1'b0;
      neg_rem      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state        <= bus.op[0] ? DIV : MUL;
          bus.busy     <= 1'b1;
          bus.div_zero <= 1'b0;
          is_div       <= bus.op[0];
          neg          <= a_neg ^ b_neg;
          neg_rem      <= a_neg;
          acc          <= '0;
          mc           <= {{WIDTH{1'b0}}, bus.op[0] ? b_mag : a_mag};
          mp           <= bus.op[0] ? a_mag : b_mag;
          cnt          <= '0;
        end
        MUL: begin
          acc <= acc + (mp[0] ? mc : '0);
          mc  <= mc << 1;
          mp  <= mp >> 1;
          cnt <= cnt + 1'b1;
          if (mul_last) state <= FIX;
        end
        DIV: if (mc[WIDTH-1:0] == '0) begin
          state        <= IDLE;
          bus.busy     <= 1'b0;
          bus.done     <= 1'b1;
          bus.div_zero <= 1'b1;
        end else begin
          acc[WIDTH-1:0] <= div_d[WIDTH] ? div_t[WIDTH-1:0] : div_d[WIDTH-1:0];
          mp             <= {mp[WIDTH-2:0], ~div_d[WIDTH]};
          cnt            <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          bus.hi   <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
          bus.lo   <= is_div ? quo : prod[WIDTH-1:0];
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (results, latency, handshake, reset, divide by zero).
module tb_muldiv_unit;
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  exp_t        sb[$];
  muldiv_unit_if #(.WIDTH(32)) bus();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint sx;
    longint sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.hi = m_hi;
    e.lo = m_lo;
    e.dz = 1'b0;
    e.lat = 33;
    if (!o[0]) begin
`ifdef MULDIV_EARLY_OUT_EN
      logic [31:0] mag;
      mag = (!o[1] && y[31]) ? -y : y;
      e.lat = 2;
      for (int i = 1; i < 32; i++) if (mag[i]) e.lat = i + 2;
`endif
      p = o[1] ? {32'h0, x} * {32'h0, y} : 64'(sx * sy);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (y == 32'h0) begin
      e.dz = 1'b1;
      e.lat = 1;
    end else if (o[1]) begin
      e.lo = x / y;
      e.hi = x % y;
    end else begin
      e.lo = 32'(sx / sy);
      e.hi = 32'(sx % sy);
    end
    m_hi = e.hi;
    m_lo = e.lo;
    return e;
  endfunction

  task automatic wait_done(input int acc);
    exp_t e;
    int nb;
    bit got;
    nb = 0;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      if (bus.busy === 1'b1) nb++;
      @(posedge clk); #1;
      got = bus.done === 1'b1;
    end
    e = sb.pop_front();
    total++;
    if (!got) begin
      bad++;
      $display("FAIL done_timeout: no done within 200 cycles, want latency %0d", e.lat);
    end else begin
      total++;
      if (bus.hi !== e.hi) begin bad++; $display("FAIL hi: got %h want %h", bus.hi, e.hi); end
      total++;
      if (bus.lo !== e.lo) begin bad++; $display("FAIL lo: got %h want %h", bus.lo, e.lo); end
      total++;
      if (bus.div_zero !== e.dz) begin bad++; $display("FAIL div_zero: got %b want %b", bus.div_zero, e.dz); end
      total++;
      if (cyc - acc != e.lat) begin bad++; $display("FAIL latency: got %0d want %0d", cyc - acc, e.lat); end
      total++;
      if (bus.busy !== 1'b0 || nb != e.lat) begin
        bad++;
        $display("FAIL busy: busy at done %b want 0, busy cycles %0d want %0d", bus.busy, nb, e.lat);
      end
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit lit, input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    e = model(o, x, y);
    if (lit) begin
      e.hi = eh;
      e.lo = el;
      m_hi = eh;
      m_lo = el;
    end
    sb.push_back(e);
    bus.op = o;
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    total++;
    if ({bus.busy, bus.div_zero} !== 2'b10) begin
      bad++;
      $display("FAIL accept: busy/div_zero got %b%b want 10", bus.busy, bus.div_zero);
    end
    wait_done(cyc);
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: busy/done/div_zero got %b%b%b want 000", bus.busy, bus.done, bus.div_zero);
    end
    total++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      bad++;
      $display("FAIL reset_hilo: got %h/%h want 0/0", bus.hi, bus.lo);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_mul;
    run_op(2'b10, 32'd3, 32'd5, 1'b1, 32'h0, 32'h0000000F);
    run_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001);
    run_op(2'b10, 32'h1234, 32'h0, 1'b1, 32'h0, 32'h0);
    run_op(2'b00, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0);
    for (int i = 0; i < 4; i++)
      run_op({1'($urandom_range(1)), 1'b0}, $urandom, $urandom >> $urandom_range(31), 1'b0, '0, '0);
  endtask

  task automatic test_div;
    run_op(2'b01, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(2'b11, 32'd7, 32'd2, 1'b1, 32'h1, 32'h3);
    run_op(2'b01, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h80000000);
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, 1'b1, 32'h1, 32'h7FFFFFFC);
    for (int i = 0; i < 4; i++)
      run_op({1'($urandom_range(1)), 1'b1}, $urandom, ($urandom >> $urandom_range(28)) | 32'h1, 1'b0, '0, '0);
  endtask

  task automatic test_div_zero;
    run_op(2'b11, 32'h2211, 32'h100, 1'b1, 32'h11, 32'h22);
    run_op(2'b01, 32'h55, 32'h0, 1'b1, 32'h11, 32'h22);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.div_zero !== 1'b1) begin bad++; $display("FAIL div_zero_hold: got %b want 1", bus.div_zero); end
    run_op(2'b10, 32'd2, 32'd3, 1'b1, 32'h0, 32'h6);
  endtask

  task automatic test_reset_mid;
    int dones;
    bus.op = 2'b00;
    bus.a = 32'hFFFFFFF0;
    bus.b = 32'h12345;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid_flags: busy/done got %b%b want 00", bus.busy, bus.done);
    end
    total++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_hilo: got %h/%h want 0/0", bus.hi, bus.lo);
    end
    m_hi = '0;
    m_lo = '0;
    @(negedge clk) reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    total++;
    if (dones != 0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort: done pulses %0d want 0, busy %b want 0", dones, bus.busy);
    end
  endtask

  task automatic test_back_to_back;
    int dones;
    sb.push_back(model(2'b10, 32'd7, 32'd9));
    sb.push_back(model(2'b11, 32'd1000, 32'd7));
    bus.op = 2'b10;
    bus.a = 32'd7;
    bus.b = 32'd9;
    bus.start = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: busy got %b want 1", bus.busy); end
    // start stays high with new operands through the whole first operation
    bus.op = 2'b11;
    bus.a = 32'd1000;
    bus.b = 32'd7;
    wait_done(cyc - 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_second_accept: busy got %b want 1", bus.busy); end
    wait_done(cyc);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    total++;
    if (dones != 0 || sb.size() != 0) begin
      bad++;
      $display("FAIL b2b_extra: done pulses %0d want 0, pending %0d want 0", dones, sb.size());
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the multicycle datapath; replaces the separate mult and div blocks with one shared engine.
- Supports signed and unsigned variants and a start/busy/done handshake so the control unit can stall on a single signal.
- Results are held internally as hi/lo and feed the Hi/Lo register muxes directly; a divide-by-zero flag feeds the exception logic.

Parameters:
- WIDTH, 32, operand width in bits; hi and lo are each WIDTH bits. Legal range is WIDTH >= 4.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request; sampled only while busy=0
- op  input  2  00=MULT signed, 01=DIV signed, 10=MULTU, 11=DIVU; latched with start
- a  input  WIDTH  multiplicand or dividend; latched with start
- b  input  WIDTH  multiplier or divisor; latched with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when hi/lo are valid
- hi  output  WIDTH  product upper half, or remainder
- lo  output  WIDTH  product lower half, or quotient
- div_zero  output  1  set when a DIV or DIVU is issued with b=0

Behaviour:
- Reset: state=IDLE; busy, done and div_zero are 0; hi and lo are 0. Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, MUL, DIV, FIX.
- IDLE: on a rising edge with start=1 (edge k):
  - a, b and op are latched; operand magnitudes are taken for signed ops; result sign flags are recorded; div_zero is cleared.
  - Next state is MUL or DIV; busy=1 from edge k.
- MUL: one shift-add step per cycle over WIDTH cycles, on edges k+1..k+WIDTH, building a 2*WIDTH unsigned product. Then go to FIX.
- DIV: one restoring shift-subtract step per cycle over WIDTH cycles, producing an unsigned quotient and remainder. Then go to FIX.
- FIX (edge k+WIDTH+1):
  - Apply signs. Product is negated if the operand signs differ. Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend.
  - Write hi/lo, set done=1, set busy=0, return to IDLE.
  - Total latency from the accepting edge to done is WIDTH+1 cycles (33 at default).
- done is high for exactly one cycle. hi/lo hold their values until the next FIX.
- Divide by zero (DIV or DIVU with b=0):
  - At edge k+1: done=1, busy=0, div_zero=1, state returns to IDLE.
  - hi and lo are unchanged.
  - div_zero stays high until the next start is accepted.
- Signed overflow: DIV of MIN by -1 gives lo=MIN (wrapped) and hi=0; no flag is raised.
- start while busy=1 is ignored and not queued.
- start at the same edge as a done pulse:
  - At the FIX edge the unit is still busy, so start is ignored.
  - At the edge after done, the new request is accepted.
- Unsigned ops ignore sign bits entirely.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: a MUL step exits to FIX as soon as the remaining (shifted) multiplier magnitude is 0, after at least 1 step.
  - Latency = (index of the highest set bit of |b|) + 2.
  - b=0 gives latency 2.
  - DIV is unaffected.
- Undefined: fixed WIDTH+1 latency for all non-zero-divisor operations.

Test Plan:
- MULTU, a=3, b=5 -> done 33 cycles after accept; hi=0x00000000, lo=0x0000000F; busy high for 33 cycles.
- MULT, a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU with a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV, a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, a=7, b=2 -> lo=3, hi=1. DIV, a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- DIV, b=0, with hi/lo previously 0x11/0x22 -> done and div_zero at the next edge; hi/lo stay 0x11/0x22. The following start clears div_zero.
- Reset asserted 10 cycles into a MULT -> busy, done, hi and lo go to 0 immediately; no done pulse. start pulses during busy -> ignored, and only one done is produced.
- With MULDIV_EARLY_OUT_EN: MULTU, a=3, b=5 -> done 4 cycles after accept, lo=15. MULTU with b=0 -> done 2 cycles after accept, result 0.
